// File: rtl/arm_fetch_queue.sv
// ARM instruction fetch/prefetch queue: credit-limited word fetches, in-order response FIFO, branch flush.
// Optional FETCH_ABORT_EN: keep a per-entry bus error and raise prefetch_abort at the head.
module arm_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_gnt,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    input  logic        fetch_err,
    output logic [31:0] code,
    output logic [31:0] code_pc,
    output logic        code_valid,
    input  logic        code_ready,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        prefetch_abort
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic          run_q, run_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [CW:0]   used;
    logic [31:0]   tgt_aligned;
    logic          addr_beat;
    logic          push;
    logic          pop;
    logic          head_err;

    // IDLE/FETCH/DRAIN are implied by credit and the discard count rather than held in a state register.
    assign used        = {1'b0, cnt_q} + {1'b0, out_q};
    assign tgt_aligned = {branch_target[31:2], 2'b00};
    assign fetch_req   = run_q & (used < DEPTH_C) & ~branch;
    assign fetch_addr  = addr_q;
    assign addr_beat   = fetch_req & fetch_gnt;
    assign push        = fetch_rvalid & (disc_q == '0) & ~branch;
    assign code_valid  = (cnt_q != '0);
    assign pop         = code_valid & code_ready & ~branch;

    always_comb begin
        run_d    = 1'b1;
        addr_d   = addr_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CW'(addr_beat) - CW'(fetch_rvalid);
        disc_d   = disc_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_d     = wr_q + PW'(push);
        rd_d     = rd_q + PW'(pop);
        if (addr_beat) begin
            addr_d = addr_q + 32'd4;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (fetch_rvalid && disc_q != '0) begin
            disc_d = disc_q - CW'(1);
        end
        if (branch) begin
            // Everything still on the bus after this edge belongs to the old stream.
            disc_d   = out_d;
            addr_d   = tgt_aligned;
            rsp_pc_d = tgt_aligned;
            cnt_d    = '0;
            wr_d     = '0;
            rd_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            addr_q   <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            cnt_q    <= '0;
            out_q    <= '0;
            disc_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            run_q    <= run_d;
            addr_q   <= addr_d;
            rsp_pc_q <= rsp_pc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= fetch_rdata;
            pc_mem[wr_q]   <= rsp_pc_q;
        end
    end

`ifdef FETCH_ABORT_EN
    logic err_mem [DEPTH];
    logic [1:0] unused_tgt_bits;

    assign unused_tgt_bits = branch_target[1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_q] <= fetch_err;
        end
    end

    assign head_err       = err_mem[rd_q];
    assign prefetch_abort = code_valid & head_err;
`else
    logic unused_bits;

    assign unused_bits    = ^{fetch_err, branch_target[1:0]};
    assign head_err       = 1'b0;
    assign prefetch_abort = 1'b0;
`endif

    assign code    = (code_valid && !head_err) ? data_mem[rd_q] : 32'h0;
    assign code_pc = code_valid ? pc_mem[rd_q] : 32'h0;

    a_rsp_underflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                       !(fetch_rvalid && out_q == '0));
    a_out_overflow:   assert property (@(posedge clk) disable iff (!rst_n)
                                       !(addr_beat && !fetch_rvalid && {1'b0, out_q} == DEPTH_C));
    a_fifo_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                       !(push && !pop && {1'b0, cnt_q} == DEPTH_C));
    a_discard_bound:  assert property (@(posedge clk) disable iff (!rst_n)
                                       disc_q <= out_q);

endmodule

// File: tb/tb_arm_fetch_queue.sv
// Randomised bench for arm_fetch_queue against an epoch-tagged bus/queue reference model.
module tb_arm_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_ABORT_EN
    localparam bit ABT = 1'b1;
`else
    localparam bit ABT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic [31:0] code;
    logic [31:0] code_pc;
    logic        code_valid;
    logic        code_ready;
    logic        branch;
    logic [31:0] branch_target;
    logic        prefetch_abort;

    arm_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .code(code), .code_pc(code_pc), .code_valid(code_valid), .code_ready(code_ready),
        .branch(branch), .branch_target(branch_target), .prefetch_abort(prefetch_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ep; } bus_t;
    typedef struct { logic [31:0] addr; bit err; } ent_t;

    bus_t        busq[$];
    ent_t        fq[$];
    int          epoch;
    logic [31:0] exp_addr;
    bit          started;
    int          cyc;
    int          first_valid;
    int          total = 0;
    int          bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic bit err_at(input logic [31:0] a);
        return (a == 32'h40) || (a[5:2] == 4'd13);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; fetch_gnt = 1'b0; fetch_rvalid = 1'b0; fetch_rdata = '0;
        fetch_err = 1'b0; code_ready = 1'b0; branch = 1'b0; branch_target = '0;
        #1;
        chk_eq("rst_fetch_req", fetch_req, 0);
        chk_eq("rst_fetch_addr", fetch_addr, RPC);
        chk_eq("rst_code_valid", code_valid, 0);
        chk_eq("rst_code", code, 0);
        chk_eq("rst_code_pc", code_pc, 0);
        chk_eq("rst_abort", prefetch_abort, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        busq.delete(); fq.delete();
        epoch = 0; exp_addr = RPC; started = 0; cyc = 0; first_valid = -1;
    endtask

    task automatic run_phase(input int n, input int pg, input int prv, input int prdy, input int pbr,
                             input bit fb, input logic [31:0] fbt);
        bus_t h;
        bit   exp_req, beat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_eq("code_valid", code_valid, fq.size() != 0);
            if (fq.size() != 0) begin
                chk_eq("code_pc", code_pc, fq[0].addr);
                chk_eq("code", code, (ABT && fq[0].err) ? 32'h0 : memw(fq[0].addr));
                chk_eq("abort", prefetch_abort, ABT && fq[0].err);
            end else begin
                chk_eq("abort_idle", prefetch_abort, 0);
            end
            if (code_valid && first_valid < 0) first_valid = cyc;

            fetch_gnt  = ($urandom_range(0, 99) < pg);
            code_ready = ($urandom_range(0, 99) < prdy);
            branch     = started && (($urandom_range(0, 99) < pbr) || (fb && i == 0));
            case ($urandom_range(0, 3))
                0: branch_target = 32'h0000_2002;
                1: branch_target = 32'hFFFF_FFF0;
                2: branch_target = 32'h0000_003A;
                default: branch_target = $urandom;
            endcase
            if (fb && i == 0) branch_target = fbt;
            if (busq.size() != 0 && $urandom_range(0, 99) < prv) begin
                fetch_rvalid = 1'b1;
                fetch_rdata  = memw(busq[0].addr);
                fetch_err    = err_at(busq[0].addr);
            end else begin
                fetch_rvalid = 1'b0;
                fetch_rdata  = $urandom;
                fetch_err    = $urandom_range(0, 1) == 1;
            end
            #1;
            exp_req = started && (fq.size() + busq.size() < DEPTH) && !branch;
            chk_eq("fetch_req", fetch_req, exp_req);
            if (exp_req) chk_eq("fetch_addr", fetch_addr, exp_addr);

            beat = exp_req && fetch_gnt;
            if (fq.size() != 0 && code_ready && !branch) void'(fq.pop_front());
            if (fetch_rvalid) begin
                h = busq.pop_front();
                if (!branch && h.ep == epoch) fq.push_back('{addr: h.addr, err: fetch_err});
            end
            if (beat) begin
                busq.push_back('{addr: exp_addr, ep: epoch});
                exp_addr = exp_addr + 32'd4;
            end
            if (branch) begin
                fq.delete();
                epoch++;
                exp_addr = {branch_target[31:2], 2'b00};
            end
            started = 1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        run_phase(20, 100, 100, 100, 0, 0, 0);
        chk_eq("first_valid_latency", first_valid, 3);
        run_phase(12, 100, 100, 0, 0, 0, 0);
        run_phase(10, 100, 100, 100, 0, 0, 0);
        run_phase(4, 100, 0, 0, 0, 0, 0);
        run_phase(16, 100, 100, 100, 0, 1, 32'h0000_2002);
        run_phase(1, 100, 100, 100, 0, 1, 32'hFFFF_FFF0);
        run_phase(6, 0, 100, 100, 0, 0, 0);
        run_phase(20, 100, 100, 100, 0, 0, 0);
        run_phase(20, 100, 70, 100, 0, 1, 32'h0000_0038);
        run_phase(400, 70, 60, 70, 8, 0, 0);
        run_phase(200, 90, 90, 30, 20, 0, 0);
        do_reset();
        run_phase(300, 60, 50, 60, 6, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
